clock_pll_sequencer: RTL and testbench
======================================

# clock_pll_sequencer

Power-up and recovery sequencer for the MMCM-based clock generator. It runs on the free-running reference clock (12.288 MHz, 81.38 ns) that feeds the MMCM. It drives the MMCM reset and power-down inputs, qualifies the asynchronous LOCKED output with a stability window, and raises `ready_o` to release the x1/x2/x4 clock domains. It retries on lock timeout or lock loss up to a limit, then parks in a sticky failed state.

## Interface
- `RST_CYCLES`, 8: cycles `pll_rst_o` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT_LOCK before the attempt fails.
- `STABLE_CYCLES`, 64: consecutive synchronized-lock cycles required before RUN.
- `MAX_RETRIES`, 3: retries allowed after the first attempt (total attempts = MAX_RETRIES+1).
- `clk_i` in 1: reference clock, single clock domain.
- `rst_i` in 1: reset, asynchronous assert, active-low.
- `pll_lock_i` in 1: MMCM LOCKED, asynchronous to `clk_i`.
- `restart_i` in 1: single-cycle request; restarts the sequence and clears the retry count.
- `pwrdwn_req_i` in 1: level; powers the MMCM down while high.
- `pll_rst_o` out 1: MMCM RST.
- `pll_pwrdwn_o` out 1: MMCM PWRDWN.
- `ready_o` out 1: clocks valid; downstream resets may release.
- `fail_o` out 1: retries exhausted; sticky.
- `lock_lost_o` out 1: lock dropped during RUN at least once; sticky.
- `retry_cnt_o` out $clog2(MAX_RETRIES+1): retries consumed.
- `state_o` out 3: current state encoding, for debug.

## Operation
- `pll_lock_i` passes through a 2-FF synchronizer to produce `lock_s`. Only `lock_s` is used.
- States: RESET, WAIT_LOCK, STABLE, RUN, FAILED, PWRDN.
- Transition priority, evaluated every cycle:
  - 1. `pwrdwn_req_i` → PWRDN.
  - 2. `restart_i` → RESET, with retry_cnt=0 and `fail_o`/`lock_lost_o` cleared.
  - 3. Per-state rules below.
- RESET: `pll_rst_o`=1 and `lock_s` is ignored. After exactly RST_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK:
  - `lock_s`=1 → STABLE.
  - After LOCK_TIMEOUT cycles without lock → failure event.
- STABLE:
  - `lock_s`=0 → WAIT_LOCK, with the timeout counter restarted.
  - STABLE_CYCLES cycles with lock held → RUN.
- RUN: `ready_o`=1. `lock_s`=0 → set `lock_lost_o`, then failure event.
- Failure event:
  - If retry_cnt==MAX_RETRIES → FAILED.
  - Otherwise retry_cnt+1 → RESET.
  - retry_cnt never wraps.
- FAILED: `pll_rst_o`=1 and `fail_o`=1. Leaves only on `restart_i` or `pwrdwn_req_i`.
- PWRDN: `pll_pwrdwn_o`=1 and `pll_rst_o`=1. When `pwrdwn_req_i` falls → RESET, with retry_cnt, `fail_o` and `lock_lost_o` cleared.
- One shared cycle counter, cleared on every state change, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1).

## Timing
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- Reset values: state RESET, `pll_rst_o`=1, `pll_pwrdwn_o`=0, `ready_o`=0, `fail_o`=0, `lock_lost_o`=0, `retry_cnt_o`=0, counter 0, synchronizer 0.
- Lock acquisition: with lock held, `ready_o` rises STABLE_CYCLES+3 edges after the first edge that samples `pll_lock_i`=1.
- Lock loss: `ready_o` falls and `pll_rst_o` rises 3 edges after the first edge that samples `pll_lock_i`=0.
- `pll_rst_o` high pulse per attempt is exactly RST_CYCLES cycles.
- `restart_i` and `pwrdwn_req_i` take effect on the next edge. A `restart_i` pulse in the same cycle as `pwrdwn_req_i`=1 is ignored.
- `rst_i` asserted mid-operation: immediate asynchronous return to reset values. The sequence restarts from RESET after deassertion.

## Structure
- Package `clock_pll_sequencer_pkg`: `state_t` enum (RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4, PWRDN=5) and a `max3` constant function for the counter width.
- Sub-module `sync_2ff`: generic single-bit two-flop synchronizer, reset to 0, instantiated for `pll_lock_i`.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal: release `rst_i`, raise lock 10 cycles later → `pll_rst_o` high exactly 4 cycles; `ready_o` rises 11 edges after lock is sampled; retry_cnt=0.
- Glitch during STABLE: lock high 5 cycles, low 1, then high → no RUN until 8 consecutive cycles; `pll_rst_o` stays 0.
- Timeout exhaustion: lock never rises → three 4-cycle `pll_rst_o` pulses, each 32 cycles apart; retry_cnt steps 1, 2; FAILED with `fail_o`=1 and `pll_rst_o` held 1.
- Lock loss in RUN: drop lock → `ready_o` falls 3 edges later, `lock_lost_o`=1, retry_cnt=1; relock → `ready_o` returns.
- Power-down: assert `pwrdwn_req_i` in RUN → `pll_pwrdwn_o`=1, `ready_o`=0 next edge. Deassert → RESET with retry_cnt=0 and flags cleared.
- Restart from FAILED: pulse `restart_i` → RESET, `fail_o`=0, retry_cnt=0. Also assert `rst_i` mid-STABLE → all outputs at reset values immediately.

Source files
------------

// File: rtl/clock_pll_sequencer_pkg.sv
// Shared types and constants for the MMCM power-up / recovery sequencer.
package clock_pll_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4,
    ST_PWRDN     = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/clock_pll_sequencer_if.sv
// MMCM control/status bundle between the sequencer (slave) and its environment (master).
interface clock_pll_sequencer_if #(
  parameter int RETRY_W = 2
);

  logic               pll_lock_i;
  logic               restart_i;
  logic               pwrdwn_req_i;
  logic               pll_rst_o;
  logic               pll_pwrdwn_o;
  logic               ready_o;
  logic               fail_o;
  logic               lock_lost_o;
  logic [RETRY_W-1:0] retry_cnt_o;
  logic [2:0]         state_o;

  modport master (
    output pll_lock_i,
    output restart_i,
    output pwrdwn_req_i,
    input  pll_rst_o,
    input  pll_pwrdwn_o,
    input  ready_o,
    input  fail_o,
    input  lock_lost_o,
    input  retry_cnt_o,
    input  state_o
  );

  modport slave (
    input  pll_lock_i,
    input  restart_i,
    input  pwrdwn_req_i,
    output pll_rst_o,
    output pll_pwrdwn_o,
    output ready_o,
    output fail_o,
    output lock_lost_o,
    output retry_cnt_o,
    output state_o
  );

endinterface

// File: rtl/clock_pll_sequencer_sync_2ff.sv
// Generic single-bit two-flop synchronizer, both flops reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clock_pll_sequencer.sv
// Sequences MMCM reset/power-down, qualifies LOCKED with a stability window,
// retries on timeout or lock loss and parks in a sticky failed state.
module clock_pll_sequencer
  import clock_pll_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  clock_pll_sequencer_if.slave bus
);

  localparam int CNT_W   = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fail_q, fail_d;
  logic               lost_q, lost_d;
  logic               pll_rst_q, pll_rst_d;
  logic               pwrdwn_q, pwrdwn_d;
  logic               ready_q, ready_d;

  logic               seq_restart;
  logic               at_max;
  state_t             fail_tgt;
  logic [RETRY_W-1:0] retry_inc;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.pll_lock_i),
    .q_o   (lock_s)
  );

  // Failure event outcome: either another attempt or the parked FAILED state.
  assign at_max    = (retry_q == RETRY_MAX);
  assign fail_tgt  = at_max ? ST_FAILED : ST_RESET;
  assign retry_inc = at_max ? retry_q : (retry_q + RETRY_W'(1));

  // next-state, counter and registered-output decode
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    fail_d      = fail_q;
    lost_d      = lost_q;
    seq_restart = 1'b0;

    if (bus.pwrdwn_req_i) begin
      state_d = ST_PWRDN;
    end else if (bus.restart_i) begin
      state_d     = ST_RESET;
      seq_restart = 1'b1;
      retry_d     = {RETRY_W{1'b0}};
      fail_d      = 1'b0;
      lost_d      = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            state_d = ST_RESET;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = fail_tgt;
            retry_d = retry_inc;
            fail_d  = fail_q | at_max;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = fail_tgt;
            retry_d = retry_inc;
            fail_d  = fail_q | at_max;
            lost_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
        ST_PWRDN: begin
          // only reached with the request already low: leave with a clean slate
          state_d     = ST_RESET;
          seq_restart = 1'b1;
          retry_d     = {RETRY_W{1'b0}};
          fail_d      = 1'b0;
          lost_d      = 1'b0;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end

    cnt_d = (seq_restart || (state_d != state_q)) ? {CNT_W{1'b0}}
          : ((cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_W'(1)));

    pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAILED) || (state_d == ST_PWRDN);
    pwrdwn_d  = (state_d == ST_PWRDN);
    ready_d   = (state_d == ST_RUN);
  end

  // state, counter, flags and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_RESET;
      cnt_q     <= {CNT_W{1'b0}};
      retry_q   <= {RETRY_W{1'b0}};
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      pwrdwn_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      fail_q    <= fail_d;
      lost_q    <= lost_d;
      pll_rst_q <= pll_rst_d;
      pwrdwn_q  <= pwrdwn_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.pll_rst_o    = pll_rst_q;
  assign bus.pll_pwrdwn_o = pwrdwn_q;
  assign bus.ready_o      = ready_q;
  assign bus.fail_o       = fail_q;
  assign bus.lock_lost_o  = lost_q;
  assign bus.retry_cnt_o  = retry_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_clock_pll_sequencer.sv
// Directed self-checking bench for clock_pll_sequencer (RST=4, TIMEOUT=32, STABLE=8, RETRIES=2).
module tb_clock_pll_sequencer;
  import clock_pll_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  always #41 clk = ~clk;

  clock_pll_sequencer_if #(.RETRY_W(2)) bus ();

  clock_pll_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.pll_lock_i   = 1'b0;
    bus.restart_i    = 1'b0;
    bus.pwrdwn_req_i = 1'b0;
    tick(3);
    chk("rst_state",  32'(bus.state_o),      32'(ST_RESET));
    chk("rst_pllrst", 32'(bus.pll_rst_o),    32'd1);
    chk("rst_pwrdwn", 32'(bus.pll_pwrdwn_o), 32'd0);
    chk("rst_ready",  32'(bus.ready_o),      32'd0);
    chk("rst_fail",   32'(bus.fail_o),       32'd0);
    chk("rst_lost",   32'(bus.lock_lost_o),  32'd0);
    chk("rst_retry",  32'(bus.retry_cnt_o),  32'd0);

    // Nominal bring-up: 4-cycle reset pulse, lock 10 cycles after release
    rst_n = 1'b1;
    tick(3);
    chk("nom_rst_e3", 32'(bus.pll_rst_o), 32'd1);
    tick(1);
    chk("nom_rst_e4", 32'(bus.pll_rst_o), 32'd0);
    chk("nom_wait",   32'(bus.state_o),   32'(ST_WAIT_LOCK));
    tick(6);
    chk("nom_wait10", 32'(bus.state_o),   32'(ST_WAIT_LOCK));
    bus.pll_lock_i = 1'b1;
    tick(2);
    chk("nom_sync_e1", 32'(bus.state_o), 32'(ST_WAIT_LOCK));
    tick(1);
    chk("nom_stable",  32'(bus.state_o), 32'(ST_STABLE));
    tick(7);
    chk("nom_ready_early", 32'(bus.ready_o), 32'd0);
    tick(1);
    chk("nom_ready",  32'(bus.ready_o),     32'd1);
    chk("nom_run",    32'(bus.state_o),     32'(ST_RUN));
    chk("nom_retry",  32'(bus.retry_cnt_o), 32'd0);
    chk("nom_pllrst", 32'(bus.pll_rst_o),   32'd0);

    // Lock loss in RUN, then relock
    bus.pll_lock_i = 1'b0;
    tick(2);
    chk("loss_ready_e1", 32'(bus.ready_o), 32'd1);
    tick(1);
    chk("loss_ready", 32'(bus.ready_o),     32'd0);
    chk("loss_rst",   32'(bus.pll_rst_o),   32'd1);
    chk("loss_lost",  32'(bus.lock_lost_o), 32'd1);
    chk("loss_retry", 32'(bus.retry_cnt_o), 32'd1);
    chk("loss_state", 32'(bus.state_o),     32'(ST_RESET));
    bus.pll_lock_i = 1'b1;
    tick(3);
    chk("loss_rst_hold", 32'(bus.pll_rst_o), 32'd1);
    tick(1);
    chk("loss_rst_end",  32'(bus.pll_rst_o), 32'd0);
    tick(8);
    chk("relock_stable", 32'(bus.state_o),     32'(ST_STABLE));
    tick(1);
    chk("relock_ready",  32'(bus.ready_o),     32'd1);
    chk("relock_lost",   32'(bus.lock_lost_o), 32'd1);
    chk("relock_retry",  32'(bus.retry_cnt_o), 32'd1);

    // Power-down from RUN; simultaneous restart must be ignored
    bus.pwrdwn_req_i = 1'b1;
    bus.restart_i    = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("pd_state",  32'(bus.state_o),      32'(ST_PWRDN));
    chk("pd_pwrdwn", 32'(bus.pll_pwrdwn_o), 32'd1);
    chk("pd_ready",  32'(bus.ready_o),      32'd0);
    chk("pd_rst",    32'(bus.pll_rst_o),    32'd1);
    chk("pd_retry",  32'(bus.retry_cnt_o),  32'd1);
    chk("pd_lost",   32'(bus.lock_lost_o),  32'd1);
    tick(3);
    chk("pd_hold", 32'(bus.state_o), 32'(ST_PWRDN));
    bus.pwrdwn_req_i = 1'b0;
    bus.pll_lock_i   = 1'b0;
    tick(1);
    chk("pdx_state",  32'(bus.state_o),      32'(ST_RESET));
    chk("pdx_pwrdwn", 32'(bus.pll_pwrdwn_o), 32'd0);
    chk("pdx_rst",    32'(bus.pll_rst_o),    32'd1);
    chk("pdx_retry",  32'(bus.retry_cnt_o),  32'd0);
    chk("pdx_lost",   32'(bus.lock_lost_o),  32'd0);
    tick(4);
    chk("pdx_wait", 32'(bus.state_o), 32'(ST_WAIT_LOCK));

    // Glitch during STABLE: 5 high, 1 low, then high
    bus.pll_lock_i = 1'b1;
    tick(5);
    bus.pll_lock_i = 1'b0;
    tick(1);
    bus.pll_lock_i = 1'b1;
    tick(2);
    chk("gl_back_wait", 32'(bus.state_o),   32'(ST_WAIT_LOCK));
    chk("gl_rst",       32'(bus.pll_rst_o), 32'd0);
    tick(8);
    chk("gl_stable",    32'(bus.state_o),   32'(ST_STABLE));
    chk("gl_ready_lo",  32'(bus.ready_o),   32'd0);
    chk("gl_rst2",      32'(bus.pll_rst_o), 32'd0);
    tick(1);
    chk("gl_ready",     32'(bus.ready_o),     32'd1);
    chk("gl_lost",      32'(bus.lock_lost_o), 32'd0);

    // Timeout exhaustion after restart with lock absent
    bus.pll_lock_i = 1'b0;
    bus.restart_i  = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("to_state0", 32'(bus.state_o),     32'(ST_RESET));
    chk("to_retry0", 32'(bus.retry_cnt_o), 32'd0);
    chk("to_ready0", 32'(bus.ready_o),     32'd0);
    tick(3);
    chk("to_p1_hold", 32'(bus.pll_rst_o), 32'd1);
    tick(1);
    chk("to_p1_end",  32'(bus.pll_rst_o), 32'd0);
    tick(31);
    chk("to_w1_last", 32'(bus.state_o),     32'(ST_WAIT_LOCK));
    chk("to_w1_retry",32'(bus.retry_cnt_o), 32'd0);
    tick(1);
    chk("to_p2_start", 32'(bus.pll_rst_o),   32'd1);
    chk("to_retry1",   32'(bus.retry_cnt_o), 32'd1);
    tick(3);
    chk("to_p2_hold",  32'(bus.pll_rst_o),   32'd1);
    tick(1);
    chk("to_p2_end",   32'(bus.pll_rst_o),   32'd0);
    tick(31);
    chk("to_w2_last",  32'(bus.pll_rst_o),   32'd0);
    tick(1);
    chk("to_p3_start", 32'(bus.pll_rst_o),   32'd1);
    chk("to_retry2",   32'(bus.retry_cnt_o), 32'd2);
    tick(4);
    chk("to_p3_end",   32'(bus.pll_rst_o),   32'd0);
    tick(31);
    chk("to_w3_last",  32'(bus.state_o),     32'(ST_WAIT_LOCK));
    chk("to_w3_fail",  32'(bus.fail_o),      32'd0);
    tick(1);
    chk("to_failed",   32'(bus.state_o),     32'(ST_FAILED));
    chk("to_fail",     32'(bus.fail_o),      32'd1);
    chk("to_rst",      32'(bus.pll_rst_o),   32'd1);
    chk("to_retry_sat",32'(bus.retry_cnt_o), 32'd2);
    tick(20);
    chk("to_park",     32'(bus.state_o),     32'(ST_FAILED));
    chk("to_park_rst", 32'(bus.pll_rst_o),   32'd1);

    // Restart from FAILED, then async reset mid-STABLE
    bus.pll_lock_i = 1'b1;
    bus.restart_i  = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("rs_state", 32'(bus.state_o),     32'(ST_RESET));
    chk("rs_fail",  32'(bus.fail_o),      32'd0);
    chk("rs_retry", 32'(bus.retry_cnt_o), 32'd0);
    chk("rs_rst",   32'(bus.pll_rst_o),   32'd1);
    tick(6);
    chk("rs_stable", 32'(bus.state_o), 32'(ST_STABLE));
    rst_n = 1'b0;
    #1;
    chk("ar_state",  32'(bus.state_o),      32'(ST_RESET));
    chk("ar_pllrst", 32'(bus.pll_rst_o),    32'd1);
    chk("ar_pwrdwn", 32'(bus.pll_pwrdwn_o), 32'd0);
    chk("ar_ready",  32'(bus.ready_o),      32'd0);
    chk("ar_fail",   32'(bus.fail_o),       32'd0);
    chk("ar_lost",   32'(bus.lock_lost_o),  32'd0);
    chk("ar_retry",  32'(bus.retry_cnt_o),  32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("ar_seq_rst",    32'(bus.pll_rst_o), 32'd1);
    tick(1);
    chk("ar_seq_wait",   32'(bus.state_o),   32'(ST_WAIT_LOCK));
    tick(1);
    chk("ar_seq_stable", 32'(bus.state_o),   32'(ST_STABLE));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
